ribm_solver: RTL and testbench

- Reformulated inversionless Berlekamp–Massey (riBM) key-equation solver for the RS(544,522) decoder over GF(2^10), t=11.
- Sits between the syndrome calculator and the Chien search / Forney stage.
- Takes 2t syndromes and runs 2t iterations, one per clock, on a 3t+1 processing-element array.
- Outputs the scaled error-locator sigma(x) and the error-evaluator terms v(x), both low order first.

---
 rtl/ribm_solver.sv | 170 +++++++++++++++++
 tb/tb_ribm_solver.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ribm_solver.sv
// riBM key-equation solver for RS(544,522) over GF(2^10), t=11.
// 2T syndromes in, one riBM iteration per clock on a 3T+1 PE datapath,
// scaled error locator (lambda) and evaluator terms (delta[0..T-1]) out.
//
// state | meaning
// IDLE  | waiting for a start with valid syndromes
// RUN   | iterating, r counts 0..2T-1
// DONE  | result registered and held; a new start may be accepted
module ribm_solver #(
  parameter int T = 11,
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] syn_i [0:2*T],
  input  logic         syn_valid_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         result_valid_o,
  output logic [W-1:0] sigma_bus_o [0:T],
  output logic [W-1:0] v_bus_o [0:T-1],
  output logic [W-1:0] omega_bus_o [0:T-1]
);

  localparam int N2T = 2 * T;
  localparam int RW = $clog2(N2T);
  // x^10 = x^3 + 1 reduction term of the primitive polynomial
  localparam logic [W-1:0] POLY = W'(10'h009);
  localparam logic [RW-1:0] LAST = RW'(N2T - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [W-1:0] lambda [0:T];
  logic [W-1:0] b [0:T];
  logic [W-1:0] delta [0:N2T-1];
  logic [W-1:0] theta [0:N2T-1];
  logic [W-1:0] gamma;
  logic signed [5:0] k;
  logic [RW-1:0] r;

  logic [W-1:0] lam_nx [0:T];
  logic [W-1:0] b_nx [0:T];
  logic [W-1:0] del_nx [0:N2T-1];
  logic [W-1:0] th_nx [0:N2T-1];
  logic [W-1:0] gam_nx;
  logic signed [5:0] k_nx;
  logic [W-1:0] d;
  logic swap;
  logic accept;
  logic last;

  // syn_i[0] carries no syndrome
  logic syn0_unused;
  assign syn0_unused = ^syn_i[0];

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] m);
    logic [W-1:0] p;
    logic [W-1:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < W; i++) begin
      if (m[i]) p = p ^ aa;
      aa = {aa[W-2:0], 1'b0} ^ (aa[W-1] ? POLY : '0);
    end
    return p;
  endfunction

  assign d      = delta[0];
  assign accept = start_i && syn_valid_i && (state != RUN);
  assign last   = (state == RUN) && (r == LAST);
  assign busy_o = (state == RUN);
  assign omega_bus_o = v_bus_o;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = RUN;
      RUN:        if (last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // one riBM iteration computed from the current register contents
  always_comb begin
    lam_nx = lambda;
    b_nx   = b;
    del_nx = delta;
    th_nx  = theta;
    gam_nx = gamma;
    k_nx   = k;
    swap   = (d != '0) && !k[5];

    lam_nx[0] = gf_mul(gamma, lambda[0]);
    for (int i = 1; i <= T; i++)
      lam_nx[i] = gf_mul(gamma, lambda[i]) ^ gf_mul(d, b[i-1]);
    for (int i = 0; i < N2T - 1; i++)
      del_nx[i] = gf_mul(gamma, delta[i+1]) ^ gf_mul(d, theta[i]);
    del_nx[N2T-1] = gf_mul(d, theta[N2T-1]);

    if (swap) begin
      b_nx = lambda;
      for (int i = 0; i < N2T - 1; i++) th_nx[i] = delta[i+1];
      th_nx[N2T-1] = '0;
      gam_nx = d;
      k_nx = -k - 6'sd1;
    end else begin
      b_nx[0] = '0;
      for (int i = 1; i <= T; i++) b_nx[i] = b[i-1];
      k_nx = k + 6'sd1;
    end
  end

  // datapath load, iterate, and result capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lambda         <= '{default: '0};
      b              <= '{default: '0};
      delta          <= '{default: '0};
      theta          <= '{default: '0};
      gamma          <= '0;
      k              <= '0;
      r              <= '0;
      done_o         <= 1'b0;
      result_valid_o <= 1'b0;
      sigma_bus_o    <= '{default: '0};
      v_bus_o        <= '{default: '0};
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        lambda    <= '{default: '0};
        lambda[0] <= W'(1);
        b         <= '{default: '0};
        b[0]      <= W'(1);
        for (int i = 0; i < N2T; i++) begin
          delta[i] <= syn_i[i+1];
          theta[i] <= syn_i[i+1];
        end
        gamma          <= W'(1);
        k              <= '0;
        r              <= '0;
        result_valid_o <= 1'b0;
      end else if (state == RUN) begin
        lambda <= lam_nx;
        b      <= b_nx;
        delta  <= del_nx;
        theta  <= th_nx;
        gamma  <= gam_nx;
        k      <= k_nx;
        r      <= r + 1'b1;
        if (last) begin
          done_o         <= 1'b1;
          result_valid_o <= 1'b1;
          sigma_bus_o    <= lam_nx;
          for (int i = 0; i < T; i++) v_bus_o[i] <= del_nx[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ribm_solver.sv
// Self-checking bench for ribm_solver: table-based GF(2^10) arithmetic,
// syndromes built from injected errors, software riBM reference and a
// root search on the returned locator.
module tb_ribm_solver;
  localparam int T = 11;
  localparam int W = 10;
  localparam int N2T = 22;

  logic clk = 1'b0;
  logic rst, start, syn_valid, busy, done, rv;
  logic [W-1:0] syn [0:N2T];
  logic [W-1:0] sigma [0:T];
  logic [W-1:0] v [0:T-1];
  logic [W-1:0] omega [0:T-1];

  int checks = 0;
  int failures = 0;
  int gexp [0:1022];
  int glog [0:1023];
  int s_ref [1:N2T];
  int m_sig [0:T];
  int m_v [0:T-1];
  int locs [$];

  always #5 clk = ~clk;

  ribm_solver #(.T(T), .W(W)) dut (
    .clk_i(clk), .rst_i(rst), .syn_i(syn), .syn_valid_i(syn_valid),
    .start_i(start), .busy_o(busy), .done_o(done), .result_valid_o(rv),
    .sigma_bus_o(sigma), .v_bus_o(v), .omega_bus_o(omega)
  );

  function automatic int gmul(input int a, input int m);
    if (a == 0 || m == 0) return 0;
    return gexp[(glog[a] + glog[m]) % 1023];
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 1023; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & 1024) != 0) x = x ^ 1033;
    end
  endtask

  // random error pattern of weight nu -> syndromes S_1..S_22
  task automatic set_errors(input int nu);
    bit used [0:543];
    int loc, val;
    used = '{default: 1'b0};
    locs.delete();
    for (int j = 1; j <= N2T; j++) s_ref[j] = 0;
    for (int e = 0; e < nu; e++) begin
      do loc = int'($urandom_range(0, 543)); while (used[loc]);
      used[loc] = 1'b1;
      locs.push_back(loc);
      val = int'($urandom_range(1, 1023));
      for (int j = 1; j <= N2T; j++) s_ref[j] = s_ref[j] ^ gmul(val, gexp[(j * loc) % 1023]);
    end
  endtask

  // software riBM over s_ref
  task automatic ref_model();
    int lam [0:T]; int bb [0:T]; int nl [0:T];
    int del [0:N2T-1]; int th [0:N2T-1]; int nd [0:N2T-1];
    int g, kk, dd;
    lam = '{default: 0}; lam[0] = 1;
    bb = '{default: 0}; bb[0] = 1;
    for (int i = 0; i < N2T; i++) begin del[i] = s_ref[i+1]; th[i] = s_ref[i+1]; end
    g = 1; kk = 0;
    for (int it = 0; it < N2T; it++) begin
      dd = del[0];
      nl[0] = gmul(g, lam[0]);
      for (int i = 1; i <= T; i++) nl[i] = gmul(g, lam[i]) ^ gmul(dd, bb[i-1]);
      for (int i = 0; i < N2T - 1; i++) nd[i] = gmul(g, del[i+1]) ^ gmul(dd, th[i]);
      nd[N2T-1] = gmul(dd, th[N2T-1]);
      if (dd != 0 && kk >= 0) begin
        bb = lam;
        for (int i = 0; i < N2T - 1; i++) th[i] = del[i+1];
        th[N2T-1] = 0;
        g = dd;
        kk = -kk - 1;
      end else begin
        for (int i = T; i >= 1; i--) bb[i] = bb[i-1];
        bb[0] = 0;
        kk = kk + 1;
      end
      lam = nl;
      del = nd;
    end
    for (int i = 0; i <= T; i++) m_sig[i] = lam[i];
    for (int i = 0; i < T; i++) m_v[i] = del[i];
  endtask

  // drive s_ref with a start at the current negedge; returns one negedge after acceptance
  task automatic start_op();
    syn[0] = W'($urandom);
    for (int j = 1; j <= N2T; j++) syn[j] = W'(s_ref[j]);
    start = 1'b1;
    syn_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    syn_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin cyc = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; syn_valid = 1'b0;
    for (int j = 0; j <= N2T; j++) syn[j] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, rv} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, rv}); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== '0) begin failures++; $display("FAIL reset_sigma[%0d] got=%h exp=0", i, sigma[i]); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== '0 || omega[i] !== '0) begin failures++; $display("FAIL reset_v[%0d] got=%h/%h exp=0", i, v[i], omega[i]); end
    end
  endtask

  task automatic test_zero();
    int cyc;
    for (int j = 1; j <= N2T; j++) s_ref[j] = 0;
    start_op();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b exp=1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 22) begin failures++; $display("FAIL zero_latency got=%0d exp=22", cyc); end
    checks++; if ({busy, rv} !== 2'b01) begin failures++; $display("FAIL zero_flags got=%b exp=01", {busy, rv}); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== ((i == 0) ? 10'd1 : 10'd0)) begin failures++; $display("FAIL zero_sigma[%0d] got=%h exp=%0d", i, sigma[i], i == 0); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== '0 || omega[i] !== '0) begin failures++; $display("FAIL zero_v[%0d] got=%h/%h exp=0", i, v[i], omega[i]); end
    end
    @(negedge clk);
    checks++; if ({done, rv} !== 2'b01) begin failures++; $display("FAIL zero_hold got=%b exp=01", {done, rv}); end
    checks++; if (sigma[0] !== 10'd1) begin failures++; $display("FAIL zero_hold_sigma got=%h exp=1", sigma[0]); end
  endtask

  task automatic test_single();
    int cyc;
    for (int j = 1; j <= N2T; j++) s_ref[j] = 1;
    start_op();
    wait_done(cyc);
    checks++; if (cyc !== 22) begin failures++; $display("FAIL single_latency got=%0d exp=22", cyc); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== ((i <= 1) ? 10'd1 : 10'd0)) begin failures++; $display("FAIL single_sigma[%0d] got=%h exp=%0d", i, sigma[i], i <= 1); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== ((i == 0) ? 10'd1 : 10'd0)) begin failures++; $display("FAIL single_v[%0d] got=%h exp=%0d", i, v[i], i == 0); end
      checks++; if (omega[i] !== v[i]) begin failures++; $display("FAIL single_omega[%0d] got=%h exp=%h", i, omega[i], v[i]); end
    end
  endtask

  task automatic test_random();
    int cyc, nu, roots, hits, acc, x;
    for (int n = 0; n < 22; n++) begin
      nu = (n % 11) + 1;
      set_errors(nu);
      ref_model();
      start_op();
      wait_done(cyc);
      checks++; if (cyc !== 22) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=22", n, cyc); end
      for (int i = 0; i <= T; i++) begin
        checks++; if (sigma[i] !== 10'(m_sig[i])) begin failures++; $display("FAIL rand%0d_sigma[%0d] got=%h exp=%h", n, i, sigma[i], m_sig[i]); end
      end
      for (int i = 0; i < T; i++) begin
        checks++; if (v[i] !== 10'(m_v[i])) begin failures++; $display("FAIL rand%0d_v[%0d] got=%h exp=%h", n, i, v[i], m_v[i]); end
        checks++; if (omega[i] !== 10'(m_v[i])) begin failures++; $display("FAIL rand%0d_omega[%0d] got=%h exp=%h", n, i, omega[i], m_v[i]); end
      end
      roots = 0;
      hits = 0;
      for (int p = 0; p < 544; p++) begin
        x = gexp[(1023 - p) % 1023];
        acc = 0;
        for (int i = T; i >= 0; i--) acc = gmul(acc, x) ^ int'(sigma[i]);
        if (acc == 0) begin
          roots++;
          foreach (locs[e]) if (locs[e] == p) hits++;
        end
      end
      checks++; if (roots !== nu) begin failures++; $display("FAIL rand%0d_root_count got=%0d exp=%0d", n, roots, nu); end
      checks++; if (hits !== nu) begin failures++; $display("FAIL rand%0d_root_locs got=%0d exp=%0d", n, hits, nu); end
    end
  endtask

  task automatic test_ignored();
    int cyc;
    set_errors(5);
    ref_model();
    for (int j = 1; j <= N2T; j++) syn[j] = W'(s_ref[j]);
    start = 1'b1;
    syn_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, rv} !== 2'b01) begin failures++; $display("FAIL novalid_start got=%b exp=01", {busy, rv}); end
    start_op();
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin cyc = c; break; end
      if (c == 5) begin
        for (int j = 1; j <= N2T; j++) syn[j] = W'($urandom);
        start = 1'b1;
        syn_valid = 1'b1;
      end else begin
        start = 1'b0;
        syn_valid = 1'b0;
      end
    end
    start = 1'b0;
    syn_valid = 1'b0;
    checks++; if (cyc !== 22) begin failures++; $display("FAIL ignore_latency got=%0d exp=22", cyc); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== 10'(m_sig[i])) begin failures++; $display("FAIL ignore_sigma[%0d] got=%h exp=%h", i, sigma[i], m_sig[i]); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== 10'(m_v[i])) begin failures++; $display("FAIL ignore_v[%0d] got=%h exp=%h", i, v[i], m_v[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    set_errors(7);
    start_op();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, rv} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {busy, done, rv}); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== '0) begin failures++; $display("FAIL midrst_sigma[%0d] got=%h exp=0", i, sigma[i]); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== '0) begin failures++; $display("FAIL midrst_v[%0d] got=%h exp=0", i, v[i]); end
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    set_errors(4);
    ref_model();
    start_op();
    wait_done(cyc);
    checks++; if (cyc !== 22) begin failures++; $display("FAIL midrst_latency got=%0d exp=22", cyc); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== 10'(m_sig[i])) begin failures++; $display("FAIL midrst_sigma2[%0d] got=%h exp=%h", i, sigma[i], m_sig[i]); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== 10'(m_v[i])) begin failures++; $display("FAIL midrst_v2[%0d] got=%h exp=%h", i, v[i], m_v[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_errors(3);
    ref_model();
    start_op();
    wait_done(cyc);
    checks++; if (cyc !== 22) begin failures++; $display("FAIL b2b_latency1 got=%0d exp=22", cyc); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== 10'(m_sig[i])) begin failures++; $display("FAIL b2b_sigma1[%0d] got=%h exp=%h", i, sigma[i], m_sig[i]); end
    end
    set_errors(9);
    ref_model();
    start_op();
    checks++; if ({busy, done, rv} !== 3'b100) begin failures++; $display("FAIL b2b_restart got=%b exp=100", {busy, done, rv}); end
    wait_done(cyc);
    checks++; if (cyc !== 22) begin failures++; $display("FAIL b2b_latency2 got=%0d exp=22", cyc); end
    checks++; if (rv !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", rv); end
    for (int i = 0; i <= T; i++) begin
      checks++; if (sigma[i] !== 10'(m_sig[i])) begin failures++; $display("FAIL b2b_sigma2[%0d] got=%h exp=%h", i, sigma[i], m_sig[i]); end
    end
    for (int i = 0; i < T; i++) begin
      checks++; if (v[i] !== 10'(m_v[i])) begin failures++; $display("FAIL b2b_v2[%0d] got=%h exp=%h", i, v[i], m_v[i]); end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_zero();
    test_single();
    test_random();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
